// File: rtl/cache_mem_responder.sv
// Memory-side responder: a line RAM with byte-enabled writes and in-order,
// fixed-latency tagged read responses. Define MEM_RESPONDER_PERF_EN to add perf counters.
module cache_mem_responder #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 26,
   parameter int TAG_WIDTH  = 8,
   parameter int MEM_LINES  = 256,
   parameter int LATENCY    = 4,
   parameter int QUEUE_SIZE = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mem_req_valid,
   input  logic                    mem_req_rw,
   input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
   input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
   input  logic [DATA_WIDTH-1:0]   mem_req_data,
   input  logic [TAG_WIDTH-1:0]    mem_req_tag,
   output logic                    mem_req_ready,
   output logic                    mem_rsp_valid,
   output logic [DATA_WIDTH-1:0]   mem_rsp_data,
   output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
   input  logic                    mem_rsp_ready
`ifdef MEM_RESPONDER_PERF_EN
   ,
   output logic [31:0]             perf_reads,
   output logic [31:0]             perf_writes,
   output logic [31:0]             perf_stalls
`endif
);

   localparam int IDX_W = $clog2(MEM_LINES);
   localparam int QW    = $clog2(QUEUE_SIZE);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [QW:0] QUEUE_FULL = (QW+1)'(QUEUE_SIZE);

   logic [DATA_WIDTH-1:0] r_mem [MEM_LINES];

   logic [LATENCY-1:0]    r_pipeValid;
   logic [DATA_WIDTH-1:0] r_pipeData [LATENCY];
   logic [TAG_WIDTH-1:0]  r_pipeTag  [LATENCY];

   logic [DATA_WIDTH-1:0] r_fifoData [QUEUE_SIZE];
   logic [TAG_WIDTH-1:0]  r_fifoTag  [QUEUE_SIZE];
   logic [QW:0]           r_wrPtr;
   logic [QW:0]           r_rdPtr;
   logic [QW:0]           r_pending;

   logic [IDX_W-1:0]      w_idx;
   logic                  w_reqFire;
   logic                  w_readFire;
   logic                  w_writeFire;
   logic                  w_rspFire;
   logic                  w_push;

   assign w_idx         = mem_req_addr[IDX_W-1:0];
   assign mem_req_ready = (r_pending != QUEUE_FULL);
   assign w_reqFire     = mem_req_valid && mem_req_ready;
   assign w_readFire    = w_reqFire && !mem_req_rw;
   assign w_writeFire   = w_reqFire && mem_req_rw;
   assign mem_rsp_valid = (r_wrPtr != r_rdPtr);
   assign w_rspFire     = mem_rsp_valid && mem_rsp_ready;
   assign w_push        = r_pipeValid[LATENCY-1];
   assign mem_rsp_data  = r_fifoData[r_rdPtr[QW-1:0]];
   assign mem_rsp_tag   = r_fifoTag[r_rdPtr[QW-1:0]];

   // Upper address bits only alias lines; they are intentionally dropped.
   generate
      if (ADDR_WIDTH > IDX_W) begin : g_unusedAddr
         logic w_unusedAddr;
         assign w_unusedAddr = ^mem_req_addr[ADDR_WIDTH-1:IDX_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_writeFire) begin
         for (int i = 0; i < BYTES; i++) begin
            if (mem_req_byteen[i]) begin
               r_mem[w_idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
            end
         end
      end
   end

   // The pipeline never stalls: credits guarantee the FIFO has room for every stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pipeValid <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            r_pipeData[s] <= '0;
            r_pipeTag[s]  <= '0;
         end
      end else begin
         r_pipeValid[0] <= w_readFire;
         r_pipeData[0]  <= r_mem[w_idx];
         r_pipeTag[0]   <= mem_req_tag;
         for (int s = 1; s < LATENCY; s++) begin
            r_pipeValid[s] <= r_pipeValid[s-1];
            r_pipeData[s]  <= r_pipeData[s-1];
            r_pipeTag[s]   <= r_pipeTag[s-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         for (int q = 0; q < QUEUE_SIZE; q++) begin
            r_fifoData[q] <= '0;
            r_fifoTag[q]  <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifoData[r_wrPtr[QW-1:0]] <= r_pipeData[LATENCY-1];
            r_fifoTag[r_wrPtr[QW-1:0]]  <= r_pipeTag[LATENCY-1];
            r_wrPtr <= r_wrPtr + (QW+1)'(1);
         end
         if (w_rspFire) begin
            r_rdPtr <= r_rdPtr + (QW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
      end else if (w_readFire && !w_rspFire) begin
         r_pending <= r_pending + (QW+1)'(1);
      end else if (!w_readFire && w_rspFire) begin
         r_pending <= r_pending - (QW+1)'(1);
      end
   end

`ifdef MEM_RESPONDER_PERF_EN
   logic [31:0] r_perfReads;
   logic [31:0] r_perfWrites;
   logic [31:0] r_perfStalls;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perfReads  <= '0;
         r_perfWrites <= '0;
         r_perfStalls <= '0;
      end else begin
         if (w_readFire) begin
            r_perfReads <= r_perfReads + 32'd1;
         end
         if (w_writeFire) begin
            r_perfWrites <= r_perfWrites + 32'd1;
         end
         if (mem_req_valid && !mem_req_ready) begin
            r_perfStalls <= r_perfStalls + 32'd1;
         end
      end
   end

   assign perf_reads  = r_perfReads;
   assign perf_writes = r_perfWrites;
   assign perf_stalls = r_perfStalls;
`endif

endmodule
